// File: rtl/axi_arbiter_w.sv
// axi_arbiter_w: two-master AXI write-channel arbiter feeding one downstream port.
// A master owns the path from AW grant until its B handshake, so only one write
// transaction is in flight at a time. s_WLAST is generated from the latched AWLEN.
//
// Build option:
//   AXI_ARB_W_FIXED_PRIO_EN  defined   -> m0 always wins a simultaneous request.
//                            undefined -> round-robin against the previous owner.

module axi_arbiter_w #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic [ADDR_WIDTH-1:0]     m0_AWADDR,
    input  logic [7:0]                m0_AWLEN,
    input  logic                      m0_AWVALID,
    output logic                      m0_AWREADY,
    input  logic [DATA_WIDTH-1:0]     m0_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   m0_WSTRB,
    input  logic                      m0_WVALID,
    output logic                      m0_WREADY,
    output logic [1:0]                m0_BRESP,
    output logic                      m0_BVALID,
    input  logic                      m0_BREADY,

    input  logic [ADDR_WIDTH-1:0]     m1_AWADDR,
    input  logic [7:0]                m1_AWLEN,
    input  logic                      m1_AWVALID,
    output logic                      m1_AWREADY,
    input  logic [DATA_WIDTH-1:0]     m1_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   m1_WSTRB,
    input  logic                      m1_WVALID,
    output logic                      m1_WREADY,
    output logic [1:0]                m1_BRESP,
    output logic                      m1_BVALID,
    input  logic                      m1_BREADY,

    output logic [ADDR_WIDTH-1:0]     s_AWADDR,
    output logic [7:0]                s_AWLEN,
    output logic                      s_AWVALID,
    input  logic                      s_AWREADY,
    output logic [DATA_WIDTH-1:0]     s_WDATA,
    output logic [DATA_WIDTH/8-1:0]   s_WSTRB,
    output logic                      s_WLAST,
    output logic                      s_WVALID,
    input  logic                      s_WREADY,
    input  logic [1:0]                s_BRESP,
    input  logic                      s_BVALID,
    output logic                      s_BREADY,

    output logic                      grant
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAw   = 2'd1;
    localparam logic [1:0] StW    = 2'd2;
    localparam logic [1:0] StB    = 2'd3;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] len_q, len_d;

    logic       st_aw, st_w, st_b;
    logic       own_awvalid, own_wvalid, own_bready;
    logic       aw_hs, w_hs, b_hs, last_beat;
    logic       pick;

    assign st_aw = (state_q == StAw);
    assign st_w  = (state_q == StW);
    assign st_b  = (state_q == StB);

    // Owner-side views, selected by the registered grant
    assign own_awvalid = grant_q ? m1_AWVALID : m0_AWVALID;
    assign own_wvalid  = grant_q ? m1_WVALID  : m0_WVALID;
    assign own_bready  = grant_q ? m1_BREADY  : m0_BREADY;

    assign aw_hs     = s_AWVALID & s_AWREADY;
    assign w_hs      = s_WVALID & s_WREADY;
    assign b_hs      = st_b & s_BVALID & own_bready;
    assign last_beat = (beat_cnt_q == len_q);

    // Arbitration decision used only in the IDLE cycle
    always_comb begin
`ifdef AXI_ARB_W_FIXED_PRIO_EN
        pick = m0_AWVALID ? 1'b0 : 1'b1;
`else
        if (m0_AWVALID && m1_AWVALID) begin
            pick = ~last_grant_q;
        end else begin
            pick = ~m0_AWVALID;
        end
`endif
    end

    // Next-state logic for the ownership FSM, burst length and beat counter
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        unique case (state_q)
            StIdle: begin
                if (m0_AWVALID || m1_AWVALID) begin
                    grant_d = pick;
                    state_d = StAw;
                end
            end
            StAw: begin
                if (aw_hs) begin
                    len_d      = s_AWLEN;
                    beat_cnt_d = 8'd0;
                    state_d    = StW;
                end
            end
            StW: begin
                if (w_hs) begin
                    // Hold on the final beat so AWLEN=255 never wraps the counter
                    if (last_beat) begin
                        state_d = StB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            StB: begin
                if (b_hs) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; last_grant=1 lets m0 win first
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            len_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
        end
    end

    // Downstream AW/W payload follows the owner; valids are gated by phase
    always_comb begin
        s_AWADDR  = grant_q ? m1_AWADDR : m0_AWADDR;
        s_AWLEN   = grant_q ? m1_AWLEN  : m0_AWLEN;
        s_AWVALID = st_aw & own_awvalid;
        s_WDATA   = grant_q ? m1_WDATA  : m0_WDATA;
        s_WSTRB   = grant_q ? m1_WSTRB  : m0_WSTRB;
        s_WVALID  = st_w & own_wvalid;
        s_WLAST   = st_w & last_beat;
        s_BREADY  = st_b & own_bready;
    end

    // Upstream handshakes reach only the owner; the non-owner sees zeros
    always_comb begin
        m0_AWREADY = st_aw & ~grant_q & s_AWREADY;
        m1_AWREADY = st_aw &  grant_q & s_AWREADY;
        m0_WREADY  = st_w  & ~grant_q & s_WREADY;
        m1_WREADY  = st_w  &  grant_q & s_WREADY;
        m0_BVALID  = st_b  & ~grant_q & s_BVALID;
        m1_BVALID  = st_b  &  grant_q & s_BVALID;
        m0_BRESP   = (st_b & ~grant_q) ? s_BRESP : 2'b00;
        m1_BRESP   = (st_b &  grant_q) ? s_BRESP : 2'b00;
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Bench for axi_arbiter_w: per-scenario tasks with inline checks, plus a
// negedge monitor that pops expected AW/W/B transfers from scoreboard queues.
`timescale 1ns/1ps

module tb_axi_arbiter_w;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [AW-1:0] m0_AWADDR, m1_AWADDR;
    logic [7:0]    m0_AWLEN, m1_AWLEN;
    logic          m0_AWVALID, m1_AWVALID, m0_AWREADY, m1_AWREADY;
    logic [DW-1:0] m0_WDATA, m1_WDATA;
    logic [SW-1:0] m0_WSTRB, m1_WSTRB;
    logic          m0_WVALID, m1_WVALID, m0_WREADY, m1_WREADY;
    logic [1:0]    m0_BRESP, m1_BRESP;
    logic          m0_BVALID, m1_BVALID, m0_BREADY, m1_BREADY;
    logic [AW-1:0] s_AWADDR;
    logic [7:0]    s_AWLEN;
    logic          s_AWVALID, s_AWREADY;
    logic [DW-1:0] s_WDATA;
    logic [SW-1:0] s_WSTRB;
    logic          s_WLAST, s_WVALID, s_WREADY;
    logic [1:0]    s_BRESP;
    logic          s_BVALID, s_BREADY;
    logic          grant;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed { logic m; logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct packed { logic m; logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } w_exp_t;
    typedef struct packed { logic m; logic [1:0] resp; } b_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    b_exp_t  b_q[$];

    axi_arbiter_w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m0_AWADDR(m0_AWADDR), .m0_AWLEN(m0_AWLEN), .m0_AWVALID(m0_AWVALID),
        .m0_AWREADY(m0_AWREADY), .m0_WDATA(m0_WDATA), .m0_WSTRB(m0_WSTRB),
        .m0_WVALID(m0_WVALID), .m0_WREADY(m0_WREADY), .m0_BRESP(m0_BRESP),
        .m0_BVALID(m0_BVALID), .m0_BREADY(m0_BREADY),
        .m1_AWADDR(m1_AWADDR), .m1_AWLEN(m1_AWLEN), .m1_AWVALID(m1_AWVALID),
        .m1_AWREADY(m1_AWREADY), .m1_WDATA(m1_WDATA), .m1_WSTRB(m1_WSTRB),
        .m1_WVALID(m1_WVALID), .m1_WREADY(m1_WREADY), .m1_BRESP(m1_BRESP),
        .m1_BVALID(m1_BVALID), .m1_BREADY(m1_BREADY),
        .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWVALID(s_AWVALID),
        .s_AWREADY(s_AWREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
        .s_WLAST(s_WLAST), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
        .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
        .grant(grant)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard monitor: every downstream handshake must match the next expected entry
    aw_exp_t    mon_aw;
    w_exp_t     mon_w;
    b_exp_t     mon_b;
    logic       mon_obv, mon_nbv;
    logic [1:0] mon_obr;
    always @(negedge ACLK) begin
        if (ARESET === 1'b0) begin
            if (s_AWVALID && s_AWREADY) begin
                n_cmp++;
                if (aw_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL aw_unexpected: got grant=%0d addr=%h len=%0d, required no AW",
                             grant, s_AWADDR, s_AWLEN);
                end else begin
                    mon_aw = aw_q.pop_front();
                    if ({grant, s_AWADDR, s_AWLEN} !== {mon_aw.m, mon_aw.addr, mon_aw.len}) begin
                        n_mis++;
                        $display("FAIL aw_xfer: got m=%0d addr=%h len=%0d, required m=%0d addr=%h len=%0d",
                                 grant, s_AWADDR, s_AWLEN, mon_aw.m, mon_aw.addr, mon_aw.len);
                    end
                end
            end
            if (s_WVALID && s_WREADY) begin
                n_cmp++;
                if (w_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL w_unexpected: got data=%h last=%0d, required no W beat",
                             s_WDATA, s_WLAST);
                end else begin
                    mon_w = w_q.pop_front();
                    if ({grant, s_WDATA, s_WSTRB, s_WLAST} !==
                        {mon_w.m, mon_w.data, mon_w.strb, mon_w.last}) begin
                        n_mis++;
                        $display("FAIL w_beat: got m=%0d data=%h strb=%h last=%0d, required m=%0d data=%h strb=%h last=%0d",
                                 grant, s_WDATA, s_WSTRB, s_WLAST,
                                 mon_w.m, mon_w.data, mon_w.strb, mon_w.last);
                    end
                end
            end
            if (s_BVALID && s_BREADY) begin
                n_cmp++;
                mon_obv = grant ? m1_BVALID : m0_BVALID;
                mon_obr = grant ? m1_BRESP  : m0_BRESP;
                mon_nbv = grant ? m0_BVALID : m1_BVALID;
                if (b_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL b_unexpected: got grant=%0d resp=%0d, required no B", grant, mon_obr);
                end else begin
                    mon_b = b_q.pop_front();
                    if ({grant, mon_obv, mon_obr, mon_nbv} !== {mon_b.m, 1'b1, mon_b.resp, 1'b0}) begin
                        n_mis++;
                        $display("FAIL b_xfer: got m=%0d bvalid=%0d resp=%0d other_bvalid=%0d, required m=%0d bvalid=1 resp=%0d other_bvalid=0",
                                 grant, mon_obv, mon_obr, mon_nbv, mon_b.m, mon_b.resp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_aw(input int m, input logic [AW-1:0] a, input logic [7:0] l, input logic v);
        if (m == 0) begin
            m0_AWADDR = a; m0_AWLEN = l; m0_AWVALID = v;
        end else begin
            m1_AWADDR = a; m1_AWLEN = l; m1_AWVALID = v;
        end
    endtask

    task automatic set_w(input int m, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic v);
        if (m == 0) begin
            m0_WDATA = d; m0_WSTRB = s; m0_WVALID = v;
        end else begin
            m1_WDATA = d; m1_WSTRB = s; m1_WVALID = v;
        end
    endtask

    task automatic set_bready(input int m, input logic v);
        if (m == 0) m0_BREADY = v;
        else        m1_BREADY = v;
    endtask

    task automatic idle_inputs();
        set_aw(0, '0, 8'd0, 1'b0);
        set_aw(1, '0, 8'd0, 1'b0);
        set_w(0, '0, '0, 1'b0);
        set_w(1, '0, '0, 1'b0);
        m0_BREADY = 1'b0; m1_BREADY = 1'b0;
        s_AWREADY = 1'b0; s_WREADY = 1'b0;
        s_BVALID = 1'b0;  s_BRESP = 2'b00;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        idle_inputs();
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    // Called one cycle into AW with s_AWREADY=1: takes the AW, sends len+1 beats, then B
    task automatic finish_owner(input int m, input logic [7:0] len, input logic [DW-1:0] dbase,
                                input logic [1:0] resp);
        logic [SW-1:0] st;
        tick();
        set_aw(m, '0, 8'd0, 1'b0);
        s_WREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            st = SW'(i + 1);
            set_w(m, dbase + DW'(i), st, 1'b1);
            w_q.push_back(w_exp_t'{m: 1'(m), data: dbase + DW'(i), strb: st,
                                   last: (i == int'(len))});
            tick();
        end
        set_w(m, '0, '0, 1'b0);
        s_BVALID = 1'b1; s_BRESP = resp;
        set_bready(m, 1'b1);
        b_q.push_back(b_exp_t'{m: 1'(m), resp: resp});
        tick();
        s_BVALID = 1'b0; s_BRESP = 2'b00;
        set_bready(m, 1'b0);
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        idle_inputs();
        set_aw(0, 32'h1, 8'd0, 1'b1);
        set_aw(1, 32'h2, 8'd0, 1'b1);
        set_w(0, 32'h3, 4'hF, 1'b1);
        m0_BREADY = 1'b1; m1_BREADY = 1'b1;
        s_AWREADY = 1'b1; s_WREADY = 1'b1; s_BVALID = 1'b1; s_BRESP = 2'b11;
        tick();
        tick();
        @(negedge ACLK);
        n_cmp++;
        if ({grant, m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID, m1_BVALID,
             s_AWVALID, s_WVALID, s_BREADY, s_WLAST} !== 11'b0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {grant, m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID,
                      m1_BVALID, s_AWVALID, s_WVALID, s_BREADY, s_WLAST});
        end
        n_cmp++;
        if ({m0_BRESP, m1_BRESP} !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_bresp: got m0=%0d m1=%0d, required 0 and 0", m0_BRESP, m1_BRESP);
        end
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        idle_inputs();
        @(negedge ACLK);
        n_cmp++;
        if ({grant, s_AWVALID} !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_idle: got grant=%0d s_AWVALID=%0d, required 0 0", grant, s_AWVALID);
        end
        tick();
    endtask

    task automatic test_single_burst();
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        set_aw(0, 32'h1000, 8'd3, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h1000, len: 8'd3});
        @(negedge ACLK);
        n_cmp++;
        if (s_AWVALID !== 1'b0) begin
            n_mis++;
            $display("FAIL aw_arb_cycle: got s_AWVALID=%0d, required 0", s_AWVALID);
        end
        tick();
        @(negedge ACLK);
        n_cmp++;
        if ({s_AWVALID, m0_AWREADY, m1_AWREADY, grant} !== 4'b1100) begin
            n_mis++;
            $display("FAIL aw_latency: got valid/rdy0/rdy1/grant=%b, required 1100",
                     {s_AWVALID, m0_AWREADY, m1_AWREADY, grant});
        end
        tick();
        set_aw(0, '0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_w(0, 32'hA000 + DW'(i), 4'hF, 1'b1);
            w_q.push_back(w_exp_t'{m: 1'b0, data: 32'hA000 + DW'(i), strb: 4'hF, last: (i == 3)});
            @(negedge ACLK);
            n_cmp++;
            if (s_WLAST !== (i == 3)) begin
                n_mis++;
                $display("FAIL wlast_beat%0d: got %0d, required %0d", i, s_WLAST, (i == 3));
            end
            tick();
        end
        set_w(0, '0, '0, 1'b0);
        s_BVALID = 1'b1; s_BRESP = 2'b00;
        m0_BREADY = 1'b1;
        b_q.push_back(b_exp_t'{m: 1'b0, resp: 2'b00});
        @(negedge ACLK);
        n_cmp++;
        if ({m0_BVALID, m0_BRESP, m1_BVALID} !== 4'b1000) begin
            n_mis++;
            $display("FAIL b_single: got bvalid0/bresp0/bvalid1=%b, required 1000",
                     {m0_BVALID, m0_BRESP, m1_BVALID});
        end
        tick();
        s_BVALID = 1'b0;
        m0_BREADY = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if ({s_AWVALID, s_WVALID, s_BREADY, m0_BVALID, s_WLAST} !== 5'b0) begin
            n_mis++;
            $display("FAIL back_to_idle: got %b, required 00000",
                     {s_AWVALID, s_WVALID, s_BREADY, m0_BVALID, s_WLAST});
        end
        tick();
    endtask

    task automatic test_arbitration();
        int first;
        do_reset();
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        set_aw(0, 32'h2000, 8'd1, 1'b1);
        set_aw(1, 32'h3000, 8'd0, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h2000, len: 8'd1});
        aw_q.push_back(aw_exp_t'{m: 1'b1, addr: 32'h3000, len: 8'd0});
        tick();
        @(negedge ACLK);
        n_cmp++;
        if ({grant, m1_AWREADY} !== 2'b00) begin
            n_mis++;
            $display("FAIL arb_first: got grant=%0d m1_AWREADY=%0d, required 0 0", grant, m1_AWREADY);
        end
        finish_owner(0, 8'd1, 32'hB000, 2'b00);
        @(negedge ACLK);
        n_cmp++;
        if (s_AWVALID !== 1'b0) begin
            n_mis++;
            $display("FAIL arb_idle_gap: got s_AWVALID=%0d, required 0", s_AWVALID);
        end
        tick();
        @(negedge ACLK);
        n_cmp++;
        if ({grant, s_AWVALID} !== 2'b11) begin
            n_mis++;
            $display("FAIL arb_second: got grant=%0d s_AWVALID=%0d, required 1 1", grant, s_AWVALID);
        end
        finish_owner(1, 8'd0, 32'hC000, 2'b01);
        // m0 alone, so m0 is the previous owner before the next contention
        set_aw(0, 32'h4000, 8'd0, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h4000, len: 8'd0});
        tick();
        finish_owner(0, 8'd0, 32'hD000, 2'b00);
`ifdef AXI_ARB_W_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        set_aw(0, 32'h5000, 8'd0, 1'b1);
        set_aw(1, 32'h6000, 8'd0, 1'b1);
        if (first == 0) begin
            aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h5000, len: 8'd0});
            aw_q.push_back(aw_exp_t'{m: 1'b1, addr: 32'h6000, len: 8'd0});
        end else begin
            aw_q.push_back(aw_exp_t'{m: 1'b1, addr: 32'h6000, len: 8'd0});
            aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h5000, len: 8'd0});
        end
        tick();
        @(negedge ACLK);
        n_cmp++;
        if (grant !== 1'(first)) begin
            n_mis++;
            $display("FAIL arb_repeat: got grant=%0d, required %0d", grant, first);
        end
        finish_owner(first, 8'd0, 32'hE100, 2'b00);
        tick();
        finish_owner(1 - first, 8'd0, 32'hE200, 2'b00);
    endtask

    task automatic test_wready_stall();
        s_AWREADY = 1'b1; s_WREADY = 1'b0;
        set_aw(0, 32'h7000, 8'd0, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h7000, len: 8'd0});
        set_w(0, 32'hDEADBEEF, 4'h5, 1'b1);
        @(negedge ACLK);
        n_cmp++;
        if ({m0_WREADY, s_WVALID} !== 2'b00) begin
            n_mis++;
            $display("FAIL w_early_idle: got wready=%0d s_wvalid=%0d, required 0 0", m0_WREADY, s_WVALID);
        end
        tick();
        @(negedge ACLK);
        n_cmp++;
        if ({m0_WREADY, s_WVALID} !== 2'b00) begin
            n_mis++;
            $display("FAIL w_early_aw: got wready=%0d s_wvalid=%0d, required 0 0", m0_WREADY, s_WVALID);
        end
        tick();
        set_aw(0, '0, 8'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            n_cmp++;
            if ({s_WVALID, s_WLAST, s_WDATA, s_WSTRB, m0_WREADY} !==
                {1'b1, 1'b1, 32'hDEADBEEF, 4'h5, 1'b0}) begin
                n_mis++;
                $display("FAIL w_stall_hold%0d: got valid=%0d last=%0d data=%h strb=%h wready=%0d, required 1 1 deadbeef 5 0",
                         k, s_WVALID, s_WLAST, s_WDATA, s_WSTRB, m0_WREADY);
            end
            tick();
        end
        s_WREADY = 1'b1;
        w_q.push_back(w_exp_t'{m: 1'b0, data: 32'hDEADBEEF, strb: 4'h5, last: 1'b1});
        @(negedge ACLK);
        n_cmp++;
        if (m0_WREADY !== 1'b1) begin
            n_mis++;
            $display("FAIL w_release: got m0_WREADY=%0d, required 1", m0_WREADY);
        end
        tick();
        set_w(0, '0, '0, 1'b0);
        s_BVALID = 1'b1;
        m0_BREADY = 1'b1;
        b_q.push_back(b_exp_t'{m: 1'b0, resp: 2'b00});
        tick();
        s_BVALID = 1'b0;
        m0_BREADY = 1'b0;
    endtask

    task automatic test_len255_block();
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        set_aw(0, 32'h8000, 8'd255, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'h8000, len: 8'd255});
        tick();
        tick();
        set_aw(0, '0, 8'd0, 1'b0);
        set_aw(1, 32'h9000, 8'd2, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b1, addr: 32'h9000, len: 8'd2});
        for (int i = 0; i < 256; i++) begin
            set_w(0, 32'h100 + DW'(i), 4'hF, 1'b1);
            w_q.push_back(w_exp_t'{m: 1'b0, data: 32'h100 + DW'(i), strb: 4'hF, last: (i == 255)});
            @(negedge ACLK);
            n_cmp++;
            if (m1_AWREADY !== 1'b0) begin
                n_mis++;
                $display("FAIL m1_blocked_beat%0d: got m1_AWREADY=%0d, required 0", i, m1_AWREADY);
            end
            tick();
        end
        set_w(0, '0, '0, 1'b0);
        s_BVALID = 1'b1;
        m0_BREADY = 1'b1;
        b_q.push_back(b_exp_t'{m: 1'b0, resp: 2'b00});
        @(negedge ACLK);
        n_cmp++;
        if ({m1_AWREADY, s_AWVALID} !== 2'b00) begin
            n_mis++;
            $display("FAIL m1_blocked_b: got m1_AWREADY=%0d s_AWVALID=%0d, required 0 0",
                     m1_AWREADY, s_AWVALID);
        end
        tick();
        s_BVALID = 1'b0;
        m0_BREADY = 1'b0;
        tick();
        @(negedge ACLK);
        n_cmp++;
        if ({grant, s_AWVALID, s_AWADDR} !== {1'b1, 1'b1, 32'h9000}) begin
            n_mis++;
            $display("FAIL m1_forwarded: got grant=%0d valid=%0d addr=%h, required 1 1 00009000",
                     grant, s_AWVALID, s_AWADDR);
        end
        finish_owner(1, 8'd2, 32'hF000, 2'b00);
    endtask

    task automatic test_bresp_hold();
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        set_aw(1, 32'hA000, 8'd0, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b1, addr: 32'hA000, len: 8'd0});
        tick();
        tick();
        set_aw(1, '0, 8'd0, 1'b0);
        set_w(1, 32'h55, 4'h3, 1'b1);
        w_q.push_back(w_exp_t'{m: 1'b1, data: 32'h55, strb: 4'h3, last: 1'b1});
        tick();
        set_w(1, '0, '0, 1'b0);
        s_BVALID = 1'b1; s_BRESP = 2'b10;
        m1_BREADY = 1'b0;
        m0_BREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge ACLK);
            n_cmp++;
            if ({s_BREADY, m1_BVALID, m1_BRESP, m0_BVALID} !== 5'b01100) begin
                n_mis++;
                $display("FAIL b_hold%0d: got sbready/bvalid1/bresp1/bvalid0=%b, required 01100",
                         k, {s_BREADY, m1_BVALID, m1_BRESP, m0_BVALID});
            end
            tick();
        end
        m1_BREADY = 1'b1;
        b_q.push_back(b_exp_t'{m: 1'b1, resp: 2'b10});
        @(negedge ACLK);
        n_cmp++;
        if ({s_BREADY, m0_BVALID} !== 2'b10) begin
            n_mis++;
            $display("FAIL b_release: got s_BREADY=%0d m0_BVALID=%0d, required 1 0", s_BREADY, m0_BVALID);
        end
        tick();
        s_BVALID = 1'b0; s_BRESP = 2'b00;
        m1_BREADY = 1'b0;
        m0_BREADY = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if ({m1_BVALID, m1_BRESP, s_BREADY} !== 4'b0000) begin
            n_mis++;
            $display("FAIL b_done_idle: got %b, required 0000", {m1_BVALID, m1_BRESP, s_BREADY});
        end
        tick();
    endtask

    task automatic test_reset_abort();
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        // m0 owns last, so without reset a contention would go to m1
        set_aw(0, 32'hB000, 8'd0, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'hB000, len: 8'd0});
        tick();
        finish_owner(0, 8'd0, 32'h1, 2'b00);
        set_aw(0, 32'hC000, 8'd3, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'hC000, len: 8'd3});
        tick();
        tick();
        set_aw(0, '0, 8'd0, 1'b0);
        set_w(0, 32'hF0, 4'hF, 1'b1);
        w_q.push_back(w_exp_t'{m: 1'b0, data: 32'hF0, strb: 4'hF, last: 1'b0});
        tick();
        set_w(0, 32'hF1, 4'hF, 1'b1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if ({grant, m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID, m1_BVALID,
             s_AWVALID, s_WVALID, s_BREADY, s_WLAST} !== 11'b0) begin
            n_mis++;
            $display("FAIL abort_outputs: got %b, required all zero",
                     {grant, m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID,
                      m1_BVALID, s_AWVALID, s_WVALID, s_BREADY, s_WLAST});
        end
        tick();
        set_w(0, '0, '0, 1'b0);
        set_aw(0, 32'hD000, 8'd0, 1'b1);
        set_aw(1, 32'hE000, 8'd0, 1'b1);
        aw_q.push_back(aw_exp_t'{m: 1'b0, addr: 32'hD000, len: 8'd0});
        aw_q.push_back(aw_exp_t'{m: 1'b1, addr: 32'hE000, len: 8'd0});
        tick();
        @(negedge ACLK);
        n_cmp++;
        if (grant !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_prio: got grant=%0d, required 0", grant);
        end
        finish_owner(0, 8'd0, 32'h2000, 2'b00);
        tick();
        finish_owner(1, 8'd0, 32'h3000, 2'b00);
    endtask

    task automatic test_drained();
        @(negedge ACLK);
        n_cmp++;
        if (aw_q.size() + w_q.size() + b_q.size() != 0) begin
            n_mis++;
            $display("FAIL drained: got aw=%0d w=%0d b=%0d pending, required 0 0 0",
                     aw_q.size(), w_q.size(), b_q.size());
        end
    endtask

    initial begin
        ARESET = 1'b1;
        idle_inputs();
        test_reset();
        test_single_burst();
        test_arbitration();
        test_wready_stall();
        test_len255_block();
        test_bresp_hold();
        test_reset_abort();
        test_drained();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
